hall_period_meter: RTL and testbench

Measures the period of a slow external pulse train (hall sensor or any divided-clock-rate signal) in system `clk` cycles. It is the counterpart of the clock divider: the divider turns `clk` into slow strobes, and this block turns a slow strobe back into a cycle count. Its output feeds the PID speed loop as the measured commutation period, with a valid pulse and a stall flag.

---
 rtl/hall_period_meter_pkg.sv | 21 ++
 rtl/hall_period_meter_sync.sv | 43 ++++
 rtl/hall_period_meter.sv | 121 ++++++++++++
 tb/tb_hall_period_meter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hall_period_meter_pkg.sv
// ---------------------------------------------------------------------------
// hall_period_meter_pkg
//   Shared definitions for the hall period meter and the PID speed path:
//   the measurement FSM state encoding and the default counter geometry.
// ---------------------------------------------------------------------------
package hall_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } hpm_state_e;

  // Defaults shared with the speed loop so both sides agree on the
  // width and the stall threshold of the commutation period.
  localparam int unsigned            HPM_CNT_W       = 16;
  localparam logic [HPM_CNT_W-1:0]   HPM_TIMEOUT     = 16'hFFFF;
  localparam int unsigned            HPM_MIN_PERIOD  = 4;
  localparam int unsigned            HPM_SYNC_STAGES = 2;

endpackage

// File: rtl/hall_period_meter_sync.sv
// ---------------------------------------------------------------------------
// pulse_edge_sync
//   Brings an asynchronous pulse into the clk domain through a SYNC_STAGES
//   flop chain, then flags each rising edge of the synchronized level with
//   a one-cycle combinational strobe. Reused for every hall input.
//
//   Ports:
//     clk       system clock
//     rst       asynchronous, active-high reset
//     pulse_in  asynchronous input level
//     rise      one-cycle strobe: synchronized level is 1, history flop is 0
//
//   SYNC_STAGES must be at least 2 for metastability protection.
// ---------------------------------------------------------------------------
module pulse_edge_sync
  import hall_period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = HPM_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: every clocked assignment uses <= so all flops sample the
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/hall_period_meter.sv
// ---------------------------------------------------------------------------
// hall_period_meter
//   Measures the period of a slow pulse train in clk cycles. The first
//   edge after idle only arms the counter; each later accepted edge latches
//   the running count. Edges closer than MIN_PERIOD to the previous accepted
//   edge are glitches. With no accepted edge for TIMEOUT cycles the input is
//   flagged stalled.
//
//   Ports:
//     clk           system clock
//     rst           asynchronous, active-high reset
//     enable        synchronous measurement enable (low forces IDLE)
//     pulse_in      asynchronous pulse to measure
//     period_out    last accepted period, in clk cycles
//     period_valid  one-cycle strobe when period_out updates
//     stalled       no accepted edge within TIMEOUT cycles
//     edge_seen     one-cycle strobe on every detected rising edge
//
//   Constraints: MIN_PERIOD < TIMEOUT <= 2**CNT_W-1, SYNC_STAGES >= 2.
// ---------------------------------------------------------------------------
module hall_period_meter
  import hall_period_meter_pkg::*;
#(
  parameter int unsigned       CNT_W       = HPM_CNT_W,
  parameter logic [CNT_W-1:0]  TIMEOUT     = CNT_W'(HPM_TIMEOUT),
  parameter int unsigned       MIN_PERIOD  = HPM_MIN_PERIOD,
  parameter int unsigned       SYNC_STAGES = HPM_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             stalled,
  output logic             edge_seen
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

  hpm_state_e       state;
  logic [CNT_W-1:0] counter;
  logic             rise;

  pulse_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      edge_seen    <= 1'b0;
    end else begin
      // Strobe defaults low; only an accepted edge raises it for one cycle.
      period_valid <= 1'b0;
      // edge_seen reports raw edges, glitches and disabled periods included.
      edge_seen    <= rise;

      if (!enable) begin
        state   <= IDLE;
        counter <= '0;
        stalled <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              // First edge only starts timing; no period exists yet.
              state   <= MEASURE;
              counter <= CNT_ONE;
            end else begin
              counter <= '0;
            end
          end

          MEASURE: begin
            if (rise && counter >= CNT_MIN) begin
              // Edge wins over a simultaneous timeout: TIMEOUT is a valid
              // period when the edge lands on the last counted cycle.
              period_out   <= counter;
              period_valid <= 1'b1;
              stalled      <= 1'b0;
              counter      <= CNT_ONE;
            end else if (!rise && counter == TIMEOUT) begin
              state   <= STALLED;
              stalled <= 1'b1;
            end else if (counter != TIMEOUT) begin
              // Glitch edges fall through here and timing continues.
              counter <= counter + CNT_ONE;
            end
          end

          STALLED: begin
            if (rise) begin
              // Restart timing; stalled clears only once a period is latched.
              state   <= MEASURE;
              counter <= CNT_ONE;
            end else begin
              counter <= TIMEOUT;
            end
          end

          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hall_period_meter.sv
// ---------------------------------------------------------------------------
// tb_hall_period_meter
//   Directed bench for hall_period_meter with TIMEOUT=300, MIN_PERIOD=4,
//   SYNC_STAGES=2. Inputs change 1 time unit after the falling clock edge;
//   a monitor tallies period_valid and edge_seen strobes on falling edges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hall_period_meter;

  localparam int unsigned      CNT_W   = 16;
  localparam logic [CNT_W-1:0] TIMEOUT = 16'd300;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             pulse_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             stalled;
  logic             edge_seen;

  int n_checks;
  int n_pass;
  int valid_cnt;
  int edge_cnt;
  int last_period;

  hall_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .MIN_PERIOD  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .stalled      (stalled),
    .edge_seen    (edge_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (period_valid) begin
        valid_cnt   = valid_cnt + 1;
        last_period = int'(period_out);
      end
      if (edge_seen) edge_cnt = edge_cnt + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One pulse: high for hi cycles, low for lo cycles (period hi+lo).
  task automatic pulse(input int hi, input int lo);
    pulse_in = 1'b1;
    tick(hi);
    pulse_in = 1'b0;
    tick(lo);
  endtask

  // Real edge, then a 2-cycle glitch starting 2 cycles later; 50 cycles total.
  task automatic glitch_train();
    pulse_in = 1'b1; tick(1);
    pulse_in = 1'b0; tick(1);
    pulse_in = 1'b1; tick(2);
    pulse_in = 1'b0; tick(46);
  endtask

  int v0, e0;

  initial begin
    n_checks = 0; n_pass = 0;
    valid_cnt = 0; edge_cnt = 0; last_period = 0;
    rst = 1'b1; enable = 1'b0; pulse_in = 1'b0;
    tick(3);
    check("rst_period_out", 32'(period_out), 0);
    check("rst_valid", 32'(period_valid), 0);
    check("rst_stalled", 32'(stalled), 0);
    check("rst_edge_seen", 32'(edge_seen), 0);
    rst = 1'b0;
    tick(2);
    enable = 1'b1;

    // Square wave, period 100: 5 edges -> 4 periods of 100.
    v0 = valid_cnt; e0 = edge_cnt;
    for (int i = 0; i < 5; i++) pulse(50, 50);
    check("sq_valid_count", 32'(valid_cnt - v0), 4);
    check("sq_edge_count", 32'(edge_cnt - e0), 5);
    check("sq_period", 32'(last_period), 100);
    check("sq_stalled", 32'(stalled), 0);

    // Glitches 2 cycles after real edges: seen, never accepted.
    v0 = valid_cnt; e0 = edge_cnt;
    glitch_train();
    glitch_train();
    pulse(25, 25);
    check("gl_edge_count", 32'(edge_cnt - e0), 5);
    check("gl_valid_count", 32'(valid_cnt - v0), 3);
    check("gl_period", 32'(last_period), 50);

    // Stop after a 100-cycle period; stall exactly 300 cycles after edge.
    pulse(50, 50);
    v0 = valid_cnt;
    pulse(50, 50);
    tick(202);
    check("st_before_timeout", 32'(stalled), 0);
    tick(1);
    check("st_at_timeout", 32'(stalled), 1);
    check("st_period_kept", 32'(period_out), 100);
    check("st_valid_count", 32'(valid_cnt - v0), 1);
    check("st_last_period", 32'(last_period), 100);
    v0 = valid_cnt;
    pulse(40, 40);
    check("rs_first_no_valid", 32'(valid_cnt - v0), 0);
    check("rs_still_stalled", 32'(stalled), 1);
    pulse(40, 40);
    check("rs_valid_count", 32'(valid_cnt - v0), 1);
    check("rs_period", 32'(last_period), 80);
    check("rs_stall_cleared", 32'(stalled), 0);

    // Edge lands on counter == TIMEOUT: edge wins.
    v0 = valid_cnt;
    pulse(150, 150);
    pulse(20, 20);
    check("to_valid_count", 32'(valid_cnt - v0), 2);
    check("to_period", 32'(last_period), 300);
    check("to_not_stalled", 32'(stalled), 0);

    // Drop enable mid-period, raise input while disabled, re-enable high.
    enable = 1'b0;
    v0 = valid_cnt;
    tick(2);
    check("en_stalled", 32'(stalled), 0);
    check("en_period_kept", 32'(period_out), 300);
    pulse_in = 1'b1;
    tick(10);
    e0 = edge_cnt;
    enable = 1'b1;
    tick(10);
    check("en_no_edge", 32'(edge_cnt - e0), 0);
    check("en_no_valid", 32'(valid_cnt - v0), 0);
    check("en_period_still", 32'(period_out), 300);
    pulse_in = 1'b0;
    tick(10);
    v0 = valid_cnt;
    pulse(30, 30);
    check("en_first_no_valid", 32'(valid_cnt - v0), 0);
    pulse(30, 30);
    check("en_valid_count", 32'(valid_cnt - v0), 1);
    check("en_period", 32'(last_period), 60);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("ar_period_out", 32'(period_out), 0);
    check("ar_valid", 32'(period_valid), 0);
    check("ar_stalled", 32'(stalled), 0);
    check("ar_edge_seen", 32'(edge_seen), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    v0 = valid_cnt;
    pulse(35, 35);
    check("ar_first_no_valid", 32'(valid_cnt - v0), 0);
    pulse(35, 35);
    check("ar_valid_count", 32'(valid_cnt - v0), 1);
    check("ar_period", 32'(period_out), 70);
    check("ar_not_stalled", 32'(stalled), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
